// File: rtl/spc7110_pkg.sv
// Shared widths, register offsets, reset defaults and FSM states for the SPC7110 data port.
package spc7110_pkg;

  localparam int unsigned ADDR_W = 24;
  localparam int unsigned OFS_W  = 6;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned HALF_W = 16;
  localparam int unsigned BLK_W  = 3;

  localparam logic [OFS_W-1:0] OFS_DATA    = 6'h10;
  localparam logic [OFS_W-1:0] OFS_PTR_L   = 6'h11;
  localparam logic [OFS_W-1:0] OFS_PTR_M   = 6'h12;
  localparam logic [OFS_W-1:0] OFS_PTR_H   = 6'h13;
  localparam logic [OFS_W-1:0] OFS_ADJ_L   = 6'h14;
  localparam logic [OFS_W-1:0] OFS_ADJ_H   = 6'h15;
  localparam logic [OFS_W-1:0] OFS_STEP_L  = 6'h16;
  localparam logic [OFS_W-1:0] OFS_STEP_H  = 6'h17;
  localparam logic [OFS_W-1:0] OFS_MODE    = 6'h18;
  localparam logic [OFS_W-1:0] OFS_ADJ_STB = 6'h1A;
  localparam logic [OFS_W-1:0] OFS_SRAM    = 6'h30;
  localparam logic [OFS_W-1:0] OFS_BLKD    = 6'h31;
  localparam logic [OFS_W-1:0] OFS_BLKE    = 6'h32;
  localparam logic [OFS_W-1:0] OFS_BLKF    = 6'h33;

  localparam logic [ADDR_W-1:0] DROM_BASE_DEF = 24'h100000;
  localparam logic [BLK_W-1:0]  BLKD_RST_DEF  = 3'd0;
  localparam logic [BLK_W-1:0]  BLKE_RST_DEF  = 3'd1;
  localparam logic [BLK_W-1:0]  BLKF_RST_DEF  = 3'd2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FETCH = 1'b1
  } dport_state_e;

endpackage

// File: rtl/spc7110_ptr_alu.sv
// Pointer post-increment and data-ROM fetch address generation (pure combinational).
module spc7110_ptr_alu
  import spc7110_pkg::*;
#(
  parameter logic [ADDR_W-1:0] DROM_BASE = DROM_BASE_DEF
) (
  input  logic [ADDR_W-1:0] ptr,
  input  logic [HALF_W-1:0] adjust,
  input  logic [HALF_W-1:0] step,
  input  logic [DATA_W-1:0] mode,
  input  logic              inc_data,
  input  logic              inc_adjust,
  input  logic [ADDR_W-1:0] rom_mask,
  output logic [ADDR_W-1:0] ptr_next,
  output logic [ADDR_W-1:0] fetch_addr
);

  logic [ADDR_W-1:0] step_ext;
  logic [ADDR_W-1:0] adjust_ext;
  logic [ADDR_W-1:0] fetch_ofs;

  assign step_ext   = mode[0] ? ADDR_W'(step) : ADDR_W'(1);
  assign adjust_ext = ADDR_W'(adjust);
  assign fetch_ofs  = mode[1] ? adjust_ext : '0;

  // Data read advances by step (or 1); adjust strobe advances by adjust; sums wrap at 24 bits.
  always_comb begin
    ptr_next = ptr;
    if (inc_data) begin
      ptr_next = ptr + step_ext;
    end else if (inc_adjust) begin
      ptr_next = ptr + adjust_ext;
    end
  end

  // Fetch address always uses the post-update pointer so the request targets the latest byte.
  assign fetch_addr = (DROM_BASE + ptr_next + fetch_ofs) & rom_mask;

endmodule

// File: rtl/spc7110_dport_ctl.sv
// SPC7110 data-ROM direct port and bank/SRAM configuration registers with one-byte prefetch.
module spc7110_dport_ctl
  import spc7110_pkg::*;
#(
  parameter logic [ADDR_W-1:0] DROM_BASE = DROM_BASE_DEF,
  parameter logic [BLK_W-1:0]  BLKD_RST  = BLKD_RST_DEF,
  parameter logic [BLK_W-1:0]  BLKE_RST  = BLKE_RST_DEF,
  parameter logic [BLK_W-1:0]  BLKF_RST  = BLKF_RST_DEF
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              reg_we,
  input  logic              reg_re,
  input  logic [OFS_W-1:0]  reg_addr,
  input  logic [DATA_W-1:0] reg_wdata,
  output logic [DATA_W-1:0] reg_rdata,
  input  logic [ADDR_W-1:0] ROM_MASK,
  output logic              rom_rd_req,
  output logic [ADDR_W-1:0] rom_rd_addr,
  input  logic              rom_rd_ack,
  input  logic [DATA_W-1:0] rom_rd_data,
  output logic              dport_busy,
  output logic              spc7110_sram_enable,
  output logic [BLK_W-1:0]  spc7110_blockd,
  output logic [BLK_W-1:0]  spc7110_blocke,
  output logic [BLK_W-1:0]  spc7110_blockf
);

  dport_state_e      state;
  logic [ADDR_W-1:0] ptr;
  logic [HALF_W-1:0] adjust;
  logic [HALF_W-1:0] step;
  logic [DATA_W-1:0] mode;
  logic [DATA_W-1:0] data_buf;
  logic              stale;

  logic [ADDR_W-1:0] ptr_w;
  logic [HALF_W-1:0] adjust_w;
  logic [HALF_W-1:0] step_w;
  logic [DATA_W-1:0] mode_w;
  logic              trig_wr;
  logic              rd_data_stb;
  logic              rd_adj_stb;
  logic              trigger;
  logic [ADDR_W-1:0] ptr_next;
  logic [ADDR_W-1:0] fetch_addr;
  logic [DATA_W-1:0] rdata_c;

  assign rd_data_stb = reg_re && (reg_addr == OFS_DATA);
  assign rd_adj_stb  = reg_re && (reg_addr == OFS_ADJ_STB);
  assign trigger     = trig_wr || rd_data_stb || rd_adj_stb;

  // Merge this cycle's register write into the pointer/adjust/step/mode values.
  always_comb begin
    ptr_w    = ptr;
    adjust_w = adjust;
    step_w   = step;
    mode_w   = mode;
    trig_wr  = 1'b0;
    if (reg_we) begin
      trig_wr = 1'b1;
      case (reg_addr)
        OFS_PTR_L:  ptr_w[7:0]     = reg_wdata;
        OFS_PTR_M:  ptr_w[15:8]    = reg_wdata;
        OFS_PTR_H:  ptr_w[23:16]   = reg_wdata;
        OFS_ADJ_L:  adjust_w[7:0]  = reg_wdata;
        OFS_ADJ_H:  adjust_w[15:8] = reg_wdata;
        OFS_STEP_L: step_w[7:0]    = reg_wdata;
        OFS_STEP_H: step_w[15:8]   = reg_wdata;
        OFS_MODE:   mode_w         = reg_wdata;
        default:    trig_wr        = 1'b0;
      endcase
    end
  end

  spc7110_ptr_alu #(
    .DROM_BASE (DROM_BASE)
  ) u_ptr_alu (
    .ptr        (ptr_w),
    .adjust     (adjust_w),
    .step       (step_w),
    .mode       (mode_w),
    .inc_data   (rd_data_stb),
    .inc_adjust (rd_adj_stb),
    .rom_mask   (ROM_MASK),
    .ptr_next   (ptr_next),
    .fetch_addr (fetch_addr)
  );

  // Read-back mux over pre-update register state; the adjust strobe port mirrors the data byte.
  always_comb begin
    rdata_c = '0;
    case (reg_addr)
      OFS_DATA, OFS_ADJ_STB: rdata_c = data_buf;
      OFS_PTR_L:  rdata_c = ptr[7:0];
      OFS_PTR_M:  rdata_c = ptr[15:8];
      OFS_PTR_H:  rdata_c = ptr[23:16];
      OFS_ADJ_L:  rdata_c = adjust[7:0];
      OFS_ADJ_H:  rdata_c = adjust[15:8];
      OFS_STEP_L: rdata_c = step[7:0];
      OFS_STEP_H: rdata_c = step[15:8];
      OFS_MODE:   rdata_c = mode;
      OFS_SRAM:   rdata_c = {spc7110_sram_enable, 7'b0};
      OFS_BLKD:   rdata_c = {5'b0, spc7110_blockd};
      OFS_BLKE:   rdata_c = {5'b0, spc7110_blocke};
      OFS_BLKF:   rdata_c = {5'b0, spc7110_blockf};
      default:    rdata_c = '0;
    endcase
  end

  // Register file, read data and prefetch FSM; a trigger mid-fetch marks the in-flight byte stale.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state               <= ST_IDLE;
      ptr                 <= '0;
      adjust              <= '0;
      step                <= '0;
      mode                <= '0;
      data_buf            <= '0;
      stale               <= 1'b0;
      reg_rdata           <= '0;
      rom_rd_req          <= 1'b0;
      rom_rd_addr         <= '0;
      dport_busy          <= 1'b0;
      spc7110_sram_enable <= 1'b0;
      spc7110_blockd      <= BLKD_RST;
      spc7110_blocke      <= BLKE_RST;
      spc7110_blockf      <= BLKF_RST;
    end else begin
      ptr    <= ptr_next;
      adjust <= adjust_w;
      step   <= step_w;
      mode   <= mode_w;

      if (reg_re) begin
        reg_rdata <= rdata_c;
      end

      if (reg_we) begin
        case (reg_addr)
          OFS_SRAM: spc7110_sram_enable <= reg_wdata[7];
          OFS_BLKD: spc7110_blockd      <= reg_wdata[2:0];
          OFS_BLKE: spc7110_blocke      <= reg_wdata[2:0];
          OFS_BLKF: spc7110_blockf      <= reg_wdata[2:0];
          default: ;
        endcase
      end

      case (state)
        ST_IDLE: begin
          if (trigger) begin
            state       <= ST_FETCH;
            rom_rd_req  <= 1'b1;
            rom_rd_addr <= fetch_addr;
            dport_busy  <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (rom_rd_ack) begin
            if (stale || trigger) begin
              stale       <= 1'b0;
              rom_rd_addr <= fetch_addr;
            end else begin
              state      <= ST_IDLE;
              data_buf   <= rom_rd_data;
              rom_rd_req <= 1'b0;
              dport_busy <= 1'b0;
            end
          end else if (trigger) begin
            stale <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spc7110_dport_ctl.sv
// Scoreboard bench: stimulus pushes expected read data / request addresses; a monitor pops and compares.
module tb_spc7110_dport_ctl;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        reg_we = 1'b0;
  logic        reg_re = 1'b0;
  logic [5:0]  reg_addr = '0;
  logic [7:0]  reg_wdata = '0;
  logic [7:0]  reg_rdata;
  logic [23:0] ROM_MASK = 24'hFFFFFF;
  logic        rom_rd_req;
  logic [23:0] rom_rd_addr;
  logic        rom_rd_ack = 1'b0;
  logic [7:0]  rom_rd_data = '0;
  logic        dport_busy;
  logic        spc7110_sram_enable;
  logic [2:0]  spc7110_blockd, spc7110_blocke, spc7110_blockf;

  spc7110_dport_ctl dut (
    .CLK(CLK), .RST_N(RST_N), .reg_we(reg_we), .reg_re(reg_re), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .ROM_MASK(ROM_MASK),
    .rom_rd_req(rom_rd_req), .rom_rd_addr(rom_rd_addr), .rom_rd_ack(rom_rd_ack),
    .rom_rd_data(rom_rd_data), .dport_busy(dport_busy),
    .spc7110_sram_enable(spc7110_sram_enable), .spc7110_blockd(spc7110_blockd),
    .spc7110_blocke(spc7110_blocke), .spc7110_blockf(spc7110_blockf)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_pass = 0;
  int rd_q[$];
  logic [23:0] req_q[$];
  int lat = 1;

  // Reference model state
  logic [23:0] m_ptr;
  logic [15:0] m_adj, m_step;
  logic [7:0]  m_mode, m_buf;
  logic        m_sram;
  logic [2:0]  m_blk[3];
  logic [23:0] m_last;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  function automatic logic [7:0] rom_byte(input logic [23:0] a);
    if (a == 24'h101234) return 8'h5A;
    return a[7:0] ^ {a[12:8], a[15:13]} ^ a[23:16] ^ 8'hC3;
  endfunction

  function automatic logic [23:0] exp_addr();
    logic [31:0] s;
    s = 32'h100000 + 32'(m_ptr) + (m_mode[1] ? 32'(m_adj) : 32'd0);
    return s[23:0] & ROM_MASK;
  endfunction

  function automatic int model_read(input logic [5:0] a);
    case (a)
      6'h10: return int'(m_buf);
      6'h11: return int'(m_ptr[7:0]);
      6'h12: return int'(m_ptr[15:8]);
      6'h13: return int'(m_ptr[23:16]);
      6'h14: return int'(m_adj[7:0]);
      6'h15: return int'(m_adj[15:8]);
      6'h16: return int'(m_step[7:0]);
      6'h17: return int'(m_step[15:8]);
      6'h18: return int'(m_mode);
      6'h1A: return -1;
      6'h30: return m_sram ? 128 : 0;
      6'h31: return int'(m_blk[0]);
      6'h32: return int'(m_blk[1]);
      6'h33: return int'(m_blk[2]);
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_ptr = '0; m_adj = '0; m_step = '0; m_mode = '0; m_buf = '0; m_sram = 1'b0;
    m_blk[0] = 3'd0; m_blk[1] = 3'd1; m_blk[2] = 3'd2; m_last = '0;
  endtask

  task automatic cyc();
    @(posedge CLK);
    #2;
  endtask

  task automatic push_fetch();
    m_last = exp_addr();
    req_q.push_back(m_last);
  endtask

  task automatic wr(input logic [5:0] a, input logic [7:0] d);
    bit trig;
    trig = 1'b1;
    case (a)
      6'h11: m_ptr[7:0] = d;
      6'h12: m_ptr[15:8] = d;
      6'h13: m_ptr[23:16] = d;
      6'h14: m_adj[7:0] = d;
      6'h15: m_adj[15:8] = d;
      6'h16: m_step[7:0] = d;
      6'h17: m_step[15:8] = d;
      6'h18: m_mode = d;
      default: trig = 1'b0;
    endcase
    if (a == 6'h30) m_sram = d[7];
    if (a == 6'h31) m_blk[0] = d[2:0];
    if (a == 6'h32) m_blk[1] = d[2:0];
    if (a == 6'h33) m_blk[2] = d[2:0];
    if (trig) push_fetch();
    reg_addr = a; reg_wdata = d; reg_we = 1'b1;
    cyc();
    reg_we = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a);
    logic [31:0] s;
    rd_q.push_back(model_read(a));
    if (a == 6'h10) begin
      s = 32'(m_ptr) + (m_mode[0] ? 32'(m_step) : 32'd1);
      m_ptr = s[23:0];
      push_fetch();
    end else if (a == 6'h1A) begin
      s = 32'(m_ptr) + 32'(m_adj);
      m_ptr = s[23:0];
      push_fetch();
    end
    reg_addr = a; reg_re = 1'b1;
    cyc();
    reg_re = 1'b0;
  endtask

  // Wait (bounded) for the port to go quiet, then the buffer holds the last requested byte.
  task automatic settle();
    int k;
    k = 0;
    while ((rom_rd_req || dport_busy) && k < 200) begin
      cyc();
      k++;
    end
    if (k >= 200) check("settle_timeout", 32'(k), 32'd0);
    m_buf = rom_byte(m_last);
    cyc();
  endtask

  // ROM arbiter model: ack after 'lat' cycles of request, data from rom_byte.
  int cnt = 0;
  always begin
    @(posedge CLK);
    #1;
    if (rom_rd_ack) begin
      rom_rd_ack = 1'b0;
      cnt = 0;
    end else if (rom_rd_req) begin
      if (cnt >= lat) begin
        rom_rd_ack = 1'b1;
        rom_rd_data = rom_byte(rom_rd_addr);
      end else begin
        cnt++;
      end
    end else begin
      cnt = 0;
    end
  end

  // Monitor: pop expected read data one cycle after each read, expected address on each new request.
  logic re_d = 1'b0, req_d = 1'b0, ack_d = 1'b0;
  always @(negedge CLK) begin
    int e;
    if (re_d) begin
      if (rd_q.size() == 0) check("rdata_unexpected", 32'd1, 32'd0);
      else begin
        e = rd_q.pop_front();
        if (e >= 0) check("rdata", 32'(reg_rdata), 32'(e));
      end
    end
    if (rom_rd_req && (!req_d || ack_d)) begin
      if (req_q.size() == 0) check("req_unexpected", 32'(rom_rd_addr), 32'hFFFFFFFF);
      else check("req_addr", 32'(rom_rd_addr), 32'(req_q.pop_front()));
    end
    re_d = reg_re;
    req_d = rom_rd_req;
    ack_d = rom_rd_ack;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [5:0] ofs_tab[17] = '{6'h10, 6'h11, 6'h12, 6'h13, 6'h14, 6'h15, 6'h16, 6'h17, 6'h18,
                              6'h1A, 6'h30, 6'h31, 6'h32, 6'h33, 6'h3F, 6'h20, 6'h05};
  logic [23:0] mask_tab[3] = '{24'hFFFFFF, 24'h0FFFFF, 24'h1FFFFF};

  initial begin
    int k;
    model_reset();
    repeat (3) cyc();
    check("rst_req", 32'(rom_rd_req), 32'd0);
    check("rst_rdata", 32'(reg_rdata), 32'd0);
    check("rst_busy", 32'(dport_busy), 32'd0);
    check("rst_blocks", 32'({spc7110_sram_enable, spc7110_blockd, spc7110_blocke, spc7110_blockf}),
          32'({1'b0, 3'd0, 3'd1, 3'd2}));
    RST_N = 1'b1;
    cyc();

    // Basic pointer write / prefetch / data read
    lat = 2;
    ROM_MASK = 24'hFFFFFF;
    wr(6'h11, 8'h34); settle();
    wr(6'h12, 8'h12); settle();
    wr(6'h13, 8'h00); settle();
    rd(6'h10); settle();
    rd(6'h11); rd(6'h12); rd(6'h13);

    // Step mode with carry into the upper byte
    wr(6'h18, 8'h01); settle();
    wr(6'h16, 8'h10); settle();
    wr(6'h17, 8'h00); settle();
    wr(6'h11, 8'hF8); settle();
    wr(6'h12, 8'hFF); settle();
    wr(6'h13, 8'h00); settle();
    rd(6'h10); settle();
    rd(6'h11); rd(6'h12); rd(6'h13);

    // 24-bit wrap with a narrower ROM mask
    ROM_MASK = 24'h0FFFFF;
    wr(6'h18, 8'h00); settle();
    wr(6'h11, 8'hFF); settle();
    wr(6'h12, 8'hFF); settle();
    wr(6'h13, 8'hFF); settle();
    rd(6'h10); settle();
    rd(6'h11); rd(6'h13);

    // Adjust offset in fetch address and adjust strobe
    ROM_MASK = 24'hFFFFFF;
    wr(6'h14, 8'h00); settle();
    wr(6'h15, 8'h01); settle();
    wr(6'h18, 8'h02); settle();
    rd(6'h1A); settle();
    rd(6'h12); rd(6'h10); settle();

    // Trigger during fetch: first byte discarded, refetch at new address
    lat = 8;
    wr(6'h11, 8'h40);
    repeat (3) cyc();
    wr(6'h11, 8'h80);
    k = 0;
    while (!rom_rd_ack && k < 50) begin cyc(); k++; end
    check("ack_seen", 32'(rom_rd_ack), 32'd1);
    cyc();
    check("busy_after_discard", 32'({dport_busy, rom_rd_req}), 32'h3);
    cyc();
    rd(6'h10);
    check("busy_mid_refetch", 32'(dport_busy), 32'd1);
    settle();
    lat = 1;
    rd(6'h10); settle();

    // SRAM enable and bank block registers
    wr(6'h30, 8'h80);
    wr(6'h31, 8'h07);
    cyc();
    check("sram_blockd", 32'({spc7110_sram_enable, spc7110_blockd}), 32'({1'b1, 3'd7}));
    rd(6'h31); rd(6'h3F); rd(6'h30); rd(6'h32);

    // Randomized register traffic
    for (int i = 0; i < 60; i++) begin
      lat = int'($urandom_range(0, 3));
      ROM_MASK = mask_tab[$urandom_range(0, 2)];
      k = int'($urandom_range(0, 16));
      if ($urandom_range(0, 1) == 1) wr(ofs_tab[k], 8'($urandom));
      else rd(ofs_tab[k]);
      settle();
    end
    check("blk_outputs", 32'({spc7110_sram_enable, spc7110_blockd, spc7110_blocke, spc7110_blockf}),
          32'({m_sram, m_blk[0], m_blk[1], m_blk[2]}));

    // Reset in the middle of a fetch drops the request immediately
    lat = 20;
    wr(6'h11, 8'h55);
    k = 0;
    while (!rom_rd_req && k < 10) begin cyc(); k++; end
    cyc();
    RST_N = 1'b0;
    #1;
    check("rst_mid_req", 32'({rom_rd_req, dport_busy}), 32'd0);
    model_reset();
    repeat (2) cyc();
    RST_N = 1'b1;
    cyc();
    check("rst2_rdata", 32'(reg_rdata), 32'd0);
    rd(6'h31); rd(6'h32); rd(6'h33); rd(6'h11); rd(6'h30);
    repeat (3) cyc();
    check("rd_q_empty", 32'(rd_q.size()), 32'd0);
    check("req_q_empty", 32'(req_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
